// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues a one-cycle read strobe, captures and decodes the
// returned word, and presents legal instructions to a consumer until acknowledged.
module instruction_fetch #(
    parameter logic [3:0]  InstrMemEn = 4'h1,
    parameter logic [11:0] StartAddr  = 12'h000
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Start,
    output logic [15:0] address,
    output logic        nRead,
    input  logic [31:0] InstrIn,
    output logic [7:0]  Opcode,
    output logic [7:0]  Dest,
    output logic [7:0]  Src1,
    output logic [7:0]  Src2,
    output logic        InstrValid,
    input  logic        InstrAck,
    output logic        Halted,
    output logic        IllegalOp,
    output logic [11:0] PC
);

    localparam int unsigned PcW    = 12;
    localparam int unsigned FieldW = 8;
    localparam logic [FieldW-1:0] OpStop = 8'hFF;

    typedef struct packed {
        logic [FieldW-1:0] opcode;
        logic [FieldW-1:0] dest;
        logic [FieldW-1:0] src1;
        logic [FieldW-1:0] src2;
    } instr_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        PRESENT = 3'd3,
        HALT    = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [PcW-1:0] pc_q, pc_d;
    logic           nread_q, nread_d;
    logic           valid_q, valid_d;
    logic           halted_q, halted_d;
    logic           illegal_q, illegal_d;
    instr_t         instr_q, instr_d;
    instr_t         instr_in;
    logic           op_legal;

    assign instr_in = instr_t'(InstrIn);

    // Legal set: 00h-05h, 10h-13h and the Stop code FFh.
    assign op_legal = (instr_in.opcode <= 8'h05)
                   || (instr_in.opcode inside {[8'h10:8'h13]})
                   || (instr_in.opcode == OpStop);

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            pc_q      <= StartAddr;
            nread_q   <= 1'b1;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            instr_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            nread_q   <= nread_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            instr_q   <= instr_d;
        end
    end

    // nRead is asserted only for the cycle spent in ISSUE, so every entry into ISSUE drives it low.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        nread_d   = 1'b1;
        valid_d   = valid_q;
        halted_d  = halted_q;
        illegal_d = 1'b0;
        instr_d   = instr_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    pc_d    = StartAddr;
                    nread_d = 1'b0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                instr_d = instr_in;
                if (instr_in.opcode == OpStop) begin
                    halted_d = 1'b1;
                    valid_d  = 1'b0;
                    state_d  = HALT;
                end else if (op_legal) begin
                    valid_d  = 1'b1;
                    state_d  = PRESENT;
                end else begin
                    illegal_d = 1'b1;
                    pc_d      = pc_q + PcW'(1);
                    nread_d   = 1'b0;
                    state_d   = ISSUE;
                end
            end
            PRESENT: begin
                if (InstrAck) begin
                    valid_d = 1'b0;
                    pc_d    = pc_q + PcW'(1);
                    nread_d = 1'b0;
                    state_d = ISSUE;
                end
            end
            HALT: begin
                if (Start) begin
                    halted_d = 1'b0;
                    pc_d     = StartAddr;
                    nread_d  = 1'b0;
                    state_d  = ISSUE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign address    = {InstrMemEn, pc_q};
    assign nRead      = nread_q;
    assign PC         = pc_q;
    assign InstrValid = valid_q;
    assign Halted     = halted_q;
    assign IllegalOp  = illegal_q;
    assign Opcode     = instr_q.opcode;
    assign Dest       = instr_q.dest;
    assign Src1       = instr_q.src1;
    assign Src2       = instr_q.src2;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: cycle table for the basic fetch/halt flow, directed
// corner sequences, and a randomized ROM walk checked by a per-fetch scoreboard.
module tb_instruction_fetch;

    logic        Clk = 1'b0;
    logic        nReset;
    logic        Start;
    logic        InstrAck;
    logic [31:0] InstrIn;
    logic [15:0] address;
    logic        nRead;
    logic [7:0]  Opcode, Dest, Src1, Src2;
    logic        InstrValid, Halted, IllegalOp;
    logic [11:0] PC;

    int tests = 0;
    int fails = 0;

    logic [31:0] rom [4096];
    logic [7:0]  legal_ops [10];

    typedef struct {
        logic        start;
        logic        ack;
        logic        nread;
        logic [15:0] addr;
        logic        valid;
        logic        halted;
        logic        illegal;
        logic [11:0] pc;
        logic        chk_f;
        logic [31:0] fields;
    } vec_t;

    vec_t vecs [8];

    instruction_fetch dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .Start      (Start),
        .address    (address),
        .nRead      (nRead),
        .InstrIn    (InstrIn),
        .Opcode     (Opcode),
        .Dest       (Dest),
        .Src1       (Src1),
        .Src2       (Src2),
        .InstrValid (InstrValid),
        .InstrAck   (InstrAck),
        .Halted     (Halted),
        .IllegalOp  (IllegalOp),
        .PC         (PC)
    );

    always #5 Clk = ~Clk;

    // Memory samples the address on the falling edge while the read strobe is low.
    always @(negedge Clk) begin
        if (!nRead) InstrIn <= rom[address[11:0]];
    end

    function automatic bit is_legal(input logic [7:0] op);
        return (op <= 8'h05) || (op >= 8'h10 && op <= 8'h13) || (op == 8'hFF);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".nRead"}, 32'(nRead), 1);
        chk({tag, ".address"}, 32'(address), 32'h1000);
        chk({tag, ".valid"}, 32'(InstrValid), 0);
        chk({tag, ".fields"}, {Opcode, Dest, Src1, Src2}, 0);
        chk({tag, ".halted"}, 32'(Halted), 0);
        chk({tag, ".illegal"}, 32'(IllegalOp), 0);
        chk({tag, ".pc"}, 32'(PC), 0);
    endtask

    task automatic reset_dut(input string tag);
        @(negedge Clk);
        Start    = 1'b0;
        InstrAck = 1'b0;
        nReset   = 1'b0;
        #2;
        check_reset(tag);
        @(negedge Clk);
        nReset = 1'b1;
        #1;
    endtask

    initial begin
        int pulses;
        int exp_pc;
        int issue_cyc;
        bit prev_nread, prev_valid, acked, wrapped, done;
        logic [31:0] held;
        logic [7:0]  op;

        vecs[0] = '{1'b1, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1, 32'h0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 32'h01020001};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 1'b0, 12'h001, 1'b0, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0, 12'h001, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 16'h1001, 1'b0, 1'b1, 1'b0, 12'h001, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h1001, 1'b0, 1'b1, 1'b0, 12'h001, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 16'h1001, 1'b0, 1'b1, 1'b0, 12'h001, 1'b0, 32'h0};

        legal_ops = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h11, 8'h12, 8'h13};

        nReset   = 1'b0;
        Start    = 1'b0;
        InstrAck = 1'b0;
        InstrIn  = 32'h0;
        for (int a = 0; a < 4096; a++) rom[a] = 32'h0;

        // Fetch, present, ack, then Stop with ack held high throughout.
        rom[0] = 32'h01020001;
        rom[1] = 32'hFF000000;
        reset_dut("rst0");
        tick();
        chk("idle.nRead", 32'(nRead), 1);
        for (int i = 0; i < 8; i++) begin
            Start    = vecs[i].start;
            InstrAck = vecs[i].ack;
            tick();
            chk($sformatf("v%0d.nRead", i), 32'(nRead), 32'(vecs[i].nread));
            chk($sformatf("v%0d.address", i), 32'(address), 32'(vecs[i].addr));
            chk($sformatf("v%0d.valid", i), 32'(InstrValid), 32'(vecs[i].valid));
            chk($sformatf("v%0d.halted", i), 32'(Halted), 32'(vecs[i].halted));
            chk($sformatf("v%0d.illegal", i), 32'(IllegalOp), 32'(vecs[i].illegal));
            chk($sformatf("v%0d.pc", i), 32'(PC), 32'(vecs[i].pc));
            if (vecs[i].chk_f)
                chk($sformatf("v%0d.fields", i), {Opcode, Dest, Src1, Src2}, vecs[i].fields);
        end

        // Restart from HALT, then hold the consumer off for five cycles.
        rom[0]   = 32'h03112233;
        Start    = 1'b1;
        InstrAck = 1'b0;
        tick();
        chk("restart.halted", 32'(Halted), 0);
        chk("restart.nRead", 32'(nRead), 0);
        chk("restart.address", 32'(address), 32'h1000);
        Start = 1'b0;
        tick();
        tick();
        chk("stall.valid0", 32'(InstrValid), 1);
        chk("stall.fields0", {Opcode, Dest, Src1, Src2}, 32'h03112233);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("stall%0d.valid", i), 32'(InstrValid), 1);
            chk($sformatf("stall%0d.fields", i), {Opcode, Dest, Src1, Src2}, 32'h03112233);
            chk($sformatf("stall%0d.nRead", i), 32'(nRead), 1);
            chk($sformatf("stall%0d.pc", i), 32'(PC), 0);
        end
        InstrAck = 1'b1;
        tick();
        InstrAck = 1'b0;
        chk("stall.ack_valid", 32'(InstrValid), 0);
        chk("stall.ack_nRead", 32'(nRead), 0);
        chk("stall.ack_address", 32'(address), 32'h1001);
        tick();
        tick();
        chk("stall.halt_again", 32'(Halted), 1);

        // Illegal opcode skipped, next word presented.
        rom[0] = 32'h7F000000;
        rom[1] = 32'h10030405;
        reset_dut("rst1");
        pulses = 0;
        Start  = 1'b1;
        tick();
        Start = 1'b0;
        pulses += int'(IllegalOp);
        tick();
        pulses += int'(IllegalOp);
        tick();
        pulses += int'(IllegalOp);
        chk("ill.pulse", 32'(IllegalOp), 1);
        chk("ill.valid", 32'(InstrValid), 0);
        chk("ill.nRead", 32'(nRead), 0);
        chk("ill.pc", 32'(PC), 1);
        tick();
        pulses += int'(IllegalOp);
        tick();
        pulses += int'(IllegalOp);
        chk("ill.pulse_count", 32'(pulses), 1);
        chk("ill.next_valid", 32'(InstrValid), 1);
        chk("ill.next_opcode", 32'(Opcode), 32'h10);
        chk("ill.next_pc", 32'(PC), 1);

        // Asynchronous reset in the middle of ISSUE.
        reset_dut("rst2");
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("arst.in_issue", 32'(nRead), 0);
        #2;
        nReset = 1'b0;
        #1;
        check_reset("arst");
        @(negedge Clk);
        nReset = 1'b1;
        tick();
        tick();
        chk("arst.stay_idle_nRead", 32'(nRead), 1);
        chk("arst.stay_idle_valid", 32'(InstrValid), 0);

        // Randomized ROM walk through the whole address space and across the wrap.
        for (int a = 0; a < 4096; a++) begin
            if ($urandom_range(0, 3) == 0) begin
                op = 8'($urandom_range(6, 254));
                if (is_legal(op)) op = 8'h20;
            end else begin
                op = legal_ops[$urandom_range(0, 9)];
            end
            rom[a] = {op, 24'($urandom)};
        end
        rom[4095] = {8'h12, 24'($urandom)};
        reset_dut("rst3");
        exp_pc     = 0;
        issue_cyc  = -100;
        prev_nread = 1'b1;
        prev_valid = 1'b0;
        acked      = 1'b0;
        wrapped    = 1'b0;
        done       = 1'b0;
        held       = 32'h0;
        Start      = 1'b1;
        InstrAck   = 1'b0;
        for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
            tick();
            if (acked) begin
                chk("rnd.ack_clears_valid", 32'(InstrValid), 0);
                exp_pc = (exp_pc + 1) % 4096;
                if (exp_pc == 0) wrapped = 1'b1;
            end
            if (IllegalOp) begin
                chk("rnd.illegal_word", 32'(is_legal(rom[exp_pc][31:24])), 0);
                chk("rnd.illegal_latency", 32'(cyc - issue_cyc), 2);
                exp_pc = (exp_pc + 1) % 4096;
            end
            chk("rnd.pc", 32'(PC), 32'(exp_pc));
            chk("rnd.halted", 32'(Halted), 0);
            if (!nRead) begin
                chk("rnd.nRead_single", 32'(prev_nread), 1);
                chk("rnd.address", 32'(address), {16'h0, 4'h1, 12'(exp_pc)});
                issue_cyc = cyc;
                if (wrapped) begin
                    chk("wrap.address", 32'(address), 32'h1000);
                    done = 1'b1;
                end
            end
            if (InstrValid && !prev_valid) begin
                held = rom[exp_pc];
                chk("rnd.valid_legal", 32'(is_legal(held[31:24]) && held[31:24] != 8'hFF), 1);
                chk("rnd.fields", {Opcode, Dest, Src1, Src2}, held);
                chk("rnd.latency", 32'(cyc - issue_cyc), 2);
            end else if (InstrValid) begin
                chk("rnd.fields_stable", {Opcode, Dest, Src1, Src2}, held);
            end
            prev_nread = nRead;
            prev_valid = InstrValid;
            InstrAck   = 1'($urandom_range(0, 1));
            Start      = ($urandom_range(0, 7) == 0);
            acked      = InstrValid && InstrAck;
            if (acked && exp_pc == 4095) chk("wrap.opcode", 32'(Opcode), 32'h12);
        end
        chk("rnd.wrap_reached", 32'(done), 1);
        Start    = 1'b0;
        InstrAck = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter InstrMemEn, default 4'h1, meaning the address[15:12] decode value selecting instruction memory.
REQ-002 The block SHALL have parameter StartAddr, default 12'h000, meaning the word address of the first fetch.
REQ-003 The block SHALL have port Clk, input, 1, the single clock; all state changes on posedge Clk.
REQ-004 The block SHALL have port nReset, input, 1, reset that is asynchronous and active-low.
REQ-005 The block SHALL have port Start, input, 1, meaning begin fetching at StartAddr (honoured only in IDLE or HALT).
REQ-006 The block SHALL have port address, output, 16, meaning the bus address, with address[15:12]=InstrMemEn and address[11:0]=PC.
REQ-007 The block SHALL have port nRead, output, 1, meaning the active-low read strobe to instruction memory.
REQ-008 The block SHALL have port InstrIn, input, 32, meaning the instruction word driven by memory.
REQ-009 The block SHALL have ports Opcode, Dest, Src1 and Src2, each output, 8, carrying InstrIn[31:24], [23:16], [15:8] and [7:0] of the held instruction.
REQ-010 The block SHALL have port InstrValid, output, 1, meaning Opcode/Dest/Src1/Src2 hold a legal, non-stop instruction.
REQ-011 The block SHALL have port InstrAck, input, 1, meaning the consumer accepts the presented instruction.
REQ-012 The block SHALL have ports Halted (output, 1, Stop fetched) and IllegalOp (output, 1, one-cycle pulse on an undefined opcode).
REQ-013 The block SHALL have port PC, output, 12, meaning the word address of the current or held instruction.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, CAPTURE, PRESENT and HALT.
REQ-015 In IDLE with Start=1, the block SHALL load PC=StartAddr, drive nRead=0 on the next posedge and enter ISSUE.
REQ-016 ISSUE SHALL last exactly one cycle with nRead=0 and address stable, so memory captures on the intervening negedge; the block then SHALL enter CAPTURE with nRead=1.
REQ-017 In CAPTURE, the block SHALL register InstrIn into the Opcode/Dest/Src1/Src2 fields and decode it in that same cycle, with no second read.
REQ-018 Legal opcodes SHALL be 00h-05h, 10h-13h and FFh.
REQ-019 Opcode FFh (Stop) SHALL move the FSM to HALT with Halted=1, InstrValid=0 and PC unchanged.
REQ-020 Any other illegal opcode SHALL pulse IllegalOp for one cycle, SHALL NOT assert InstrValid, SHALL set PC=PC+1 and SHALL return to ISSUE.
REQ-021 A legal non-stop opcode SHALL enter PRESENT with InstrValid=1.
REQ-022 In PRESENT, all outputs SHALL hold stable until a posedge with InstrAck=1; on that edge InstrValid SHALL clear, PC SHALL become PC+1 and the FSM SHALL enter ISSUE.
REQ-023 Fetch-to-valid latency SHALL be 2 cycles (ISSUE, CAPTURE), and ack-to-next-valid latency SHALL be 3 cycles minimum.
REQ-024 PC SHALL increment modulo 4096 (12'hFFF+1 -> 12'h000) with no flag.
REQ-025 InstrAck SHALL be ignored outside PRESENT, and Start SHALL be ignored outside IDLE and HALT.
REQ-026 Start in HALT SHALL clear Halted, reload PC=StartAddr and enter ISSUE on the next posedge.
REQ-027 nRead SHALL be low only in ISSUE and never for two consecutive cycles.

Reset
REQ-028 While nReset=0, regardless of state (including mid-ISSUE), outputs SHALL be: FSM=IDLE, PC=StartAddr, address={InstrMemEn,StartAddr}, nRead=1, InstrValid=0, Opcode=Dest=Src1=Src2=00h, Halted=0, IllegalOp=0.
REQ-029 After nReset rises, the block SHALL stay in IDLE until Start.

Verification
REQ-030 The bench SHALL cover: ROM[0]=32'h01020001, ROM[1]=32'hFF000000, Start pulse, then InstrAck held 1 -> nRead low 1 cycle at address 16'h1000, InstrValid with Opcode=01h Dest=02h Src1=00h Src2=01h PC=0; then read at 16'h1001; Halted=1, PC=1, no further nRead.
REQ-031 The bench SHALL cover: InstrAck held 0 for 5 cycles in PRESENT -> fields and InstrValid stable, nRead stays 1; ack -> next ISSUE 1 cycle later.
REQ-032 The bench SHALL cover: ROM[0]=32'h7F000000, ROM[1]=32'h10030405 -> IllegalOp pulses once, then InstrValid with Opcode=10h at PC=1.
REQ-033 The bench SHALL cover: PC=12'hFFF with Opcode=12h acked -> next address 16'h1000.
REQ-034 The bench SHALL cover: nReset asserted during ISSUE -> nRead=1 and all outputs at reset values immediately, without waiting for a clock.
REQ-035 The bench SHALL cover: Start pulsed in HALT -> Halted=0, refetch from address 16'h1000.
